pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_pkg.sv | 17 +
 rtl/pong_game_ctrl_if.sv | 27 ++
 rtl/pong_frame_timer.sv | 37 +++
 rtl/pong_game_ctrl.sv | 121 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Purpose : shared state encoding and parameter defaults for the pong game controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_OVER  = 3'd3
    } pong_state_e;

    localparam int DEF_LIVES        = 3;
    localparam int DEF_SERVE_FRAMES = 120;
    localparam int DEF_OVER_FRAMES  = 180;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Purpose : bundles the game controller's frame/button/collision inputs and status outputs.
// Latency : n/a (wiring only).
// Backpressure: none; all inputs are pulses or levels sampled every clk.
// Signals: refr_tick, btn[1:0], hit, miss (to controller);
//          gra_still, ball_reset, score_bcd[7:0], lives[1:0], game_over, state[2:0] (from controller).
interface pong_game_ctrl_if;
    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       gra_still;
    logic       ball_reset;
    logic [7:0] score_bcd;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state;

    // master drives the game events, slave is the controller
    modport master (
        output refr_tick, btn, hit, miss,
        input  gra_still, ball_reset, score_bcd, lives, game_over, state
    );
    modport slave (
        input  refr_tick, btn, hit, miss,
        output gra_still, ball_reset, score_bcd, lives, game_over, state
    );
endinterface

// File: rtl/pong_frame_timer.sv
// Purpose : 8-bit frame down-counter; load wins over a coincident tick, expire = tick at zero.
// Latency : load visible next cycle; expire_o is combinational from the count and tick_i.
// Backpressure: none.
// Ports: clk, rst (async, active-high), load_i, load_val_i[7:0], tick_i, expire_o.
module pong_frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       tick_i,
    output logic       expire_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A hold of N therefore spans N+1 ticks: N decrements plus the expiring tick.
    assign expire_o = tick_i && (cnt_q == 8'd0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Purpose : pong game sequencer (IDLE -> SERVE -> PLAY -> OVER) with BCD score and lives.
// Latency : all outputs registered, one clk after the causing input.
// Backpressure: none; hit/miss/refr_tick are single-cycle pulses consumed when seen.
// Ports: clk, rst (async, active-high), bus (pong_game_ctrl_if.slave).
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES        = DEF_LIVES,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int OVER_FRAMES  = DEF_OVER_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    pong_game_ctrl_if.slave  bus
);

    pong_state_e state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic        gra_still_q, ball_reset_q, game_over_q;
    logic        btn_prev_q;
    logic        btn_any;
    logic        start;
    logic        tmr_load;
    logic [7:0]  tmr_val;
    logic        tmr_expire;

    // Edge register runs in every state, so a button held through OVER
    // is already "seen" when IDLE is entered and cannot restart the game.
    assign btn_any = bus.btn[0] | bus.btn[1];
    assign start   = btn_any & ~btn_prev_q;

    pong_frame_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tick_i     (bus.refr_tick),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        lives_d  = lives_q;
        tmr_load = 1'b0;
        tmr_val  = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    score_d  = 8'h00;
                    lives_d  = 2'(LIVES);
                    tmr_load = 1'b1;
                    tmr_val  = 8'(SERVE_FRAMES);
                    state_d  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tmr_expire) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // miss has priority: a simultaneous hit is dropped
                if (bus.miss) begin
                    lives_d  = lives_q - 2'd1;
                    tmr_load = 1'b1;
                    if (lives_q == 2'd1) begin
                        tmr_val = 8'(OVER_FRAMES);
                        state_d = ST_OVER;
                    end else begin
                        tmr_val = 8'(SERVE_FRAMES);
                        state_d = ST_SERVE;
                    end
                end else if (bus.hit) begin
                    if (score_q[3:0] == 4'd9) begin
                        score_d[3:0] = 4'd0;
                        score_d[7:4] = (score_q[7:4] == 4'd9) ? 4'd0 : score_q[7:4] + 4'd1;
                    end else begin
                        score_d[3:0] = score_q[3:0] + 4'd1;
                    end
                end
            end
            ST_OVER: begin
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            score_q      <= 8'h00;
            lives_q      <= 2'(LIVES);
            btn_prev_q   <= 1'b0;
            gra_still_q  <= 1'b1;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            btn_prev_q   <= btn_any;
            // flags follow the state being entered so they line up with state_q
            gra_still_q  <= (state_d != ST_PLAY);
            ball_reset_q <= (state_d != ST_PLAY);
            game_over_q  <= (state_d == ST_OVER);
        end
    end

    assign bus.gra_still  = gra_still_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.score_bcd  = score_q;
    assign bus.lives      = lives_q;
    assign bus.game_over  = game_over_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Purpose : self-checking bench for pong_game_ctrl: directed game scenarios plus random traffic
//           compared every cycle against a behavioural game model.
// Latency : n/a.
// Backpressure: n/a.
module tb_pong_game_ctrl;

    localparam int P_LIVES = 3;
    localparam int P_SERVE = 3;
    localparam int P_OVER  = 2;

    // model state codes
    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_OVER  = 3;

    logic clk;
    logic rst;

    pong_game_ctrl_if bus();

    pong_game_ctrl #(
        .LIVES        (P_LIVES),
        .SERVE_FRAMES (P_SERVE),
        .OVER_FRAMES  (P_OVER)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // behavioural game model: phase, ticks left in the current hold, decimal score, lives
    int m_st;
    int m_left;
    int m_score;
    int m_lives;
    bit m_prev;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = M_IDLE;
        m_left  = 0;
        m_score = 0;
        m_lives = P_LIVES;
        m_prev  = 1'b0;
    endtask

    // one clock of game rules; a tick in the cycle that enters a hold is not counted
    task automatic model_step(input bit t, input logic [1:0] b, input bit h, input bit m);
        bit start;
        start  = (b != 2'b00) && !m_prev;
        m_prev = (b != 2'b00);
        case (m_st)
            M_IDLE: if (start) begin
                m_score = 0;
                m_lives = P_LIVES;
                m_left  = P_SERVE + 1;
                m_st    = M_SERVE;
            end
            M_SERVE: if (t) begin
                m_left--;
                if (m_left == 0) m_st = M_PLAY;
            end
            M_PLAY: begin
                if (m) begin
                    m_lives--;
                    if (m_lives == 0) begin
                        m_left = P_OVER + 1;
                        m_st   = M_OVER;
                    end else begin
                        m_left = P_SERVE + 1;
                        m_st   = M_SERVE;
                    end
                end else if (h) begin
                    m_score = (m_score + 1) % 100;
                end
            end
            default: if (t) begin
                m_left--;
                if (m_left == 0) m_st = M_IDLE;
            end
        endcase
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_state"},  int'(bus.state),      m_st);
        chk({tag, "_still"},  int'(bus.gra_still),  int'(m_st != M_PLAY));
        chk({tag, "_breset"}, int'(bus.ball_reset), int'(m_st != M_PLAY));
        chk({tag, "_over"},   int'(bus.game_over),  int'(m_st == M_OVER));
        chk({tag, "_score"},  int'(bus.score_bcd),  to_bcd(m_score));
        chk({tag, "_lives"},  int'(bus.lives),      m_lives);
    endtask

    // called at a negedge; returns at the following negedge after checking
    task automatic cycle(input bit t, input logic [1:0] b, input bit h, input bit m);
        bus.refr_tick = t;
        bus.btn       = b;
        bus.hit       = h;
        bus.miss      = m;
        @(posedge clk);
        model_step(t, b, h, m);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // tick until the hold in state st ends; returns the number of ticks spent there
    task automatic hold_ticks(input int st, input logic [1:0] b, output int n);
        n = 0;
        while (int'(bus.state) == st && n < 20) begin
            cycle(1'b1, b, 1'b0, 1'b0);
            n++;
        end
        if (n >= 20) chk("hold_timeout", n, 0);
    endtask

    int n;
    logic [1:0] rb;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.refr_tick = 1'b0;
        bus.btn = 2'b00;
        bus.hit = 1'b0;
        bus.miss = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // idle, then a held button: one start only
        cycle(1'b1, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 2'b01, 1'b0, 1'b0);
        chk("start_state", int'(bus.state), M_SERVE);
        hold_ticks(M_SERVE, 2'b01, n);
        chk("serve_ticks", n, P_SERVE + 1);
        chk("play_still", int'(bus.gra_still), 0);

        // 100 hits: 09 -> 10 carry, wrap to 00
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b0, 2'b01, 1'b1, 1'b0);
            if (i == 9)  chk("score_09", int'(bus.score_bcd), 'h09);
            if (i == 10) chk("score_10", int'(bus.score_bcd), 'h10);
            if (i == 99) chk("score_99", int'(bus.score_bcd), 'h99);
            if ((i % 7) == 0) cycle(1'b1, 2'b01, 1'b0, 1'b0);
        end
        chk("score_wrap", int'(bus.score_bcd), 'h00);
        chk("lives_keep", int'(bus.lives), 3);
        repeat (3) cycle(1'b0, 2'b01, 1'b1, 1'b0);

        // three misses; the first coincides with a frame tick
        for (int k = 0; k < 3; k++) begin
            cycle((k == 0), 2'b01, 1'b0, 1'b1);
            chk("miss_lives", int'(bus.lives), 2 - k);
            if (k < 2) begin
                cycle(1'b0, 2'b01, 1'b1, 1'b0);
                chk("serve_hit_ignored", int'(bus.score_bcd), 'h03);
                hold_ticks(M_SERVE, 2'b01, n);
                chk("reserve_ticks", n, P_SERVE + 1);
            end
        end
        chk("over_state", int'(bus.state), M_OVER);
        chk("over_flag", int'(bus.game_over), 1);
        hold_ticks(M_OVER, 2'b01, n);
        chk("over_ticks", n, P_OVER + 1);
        chk("idle_after_over", int'(bus.state), M_IDLE);
        chk("score_retained", int'(bus.score_bcd), 'h03);
        repeat (6) cycle(1'b1, 2'b01, 1'b0, 1'b0);
        chk("no_restart_held", int'(bus.state), M_IDLE);

        // fresh press, hit+miss together at score 05
        cycle(1'b0, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 2'b10, 1'b0, 1'b0);
        hold_ticks(M_SERVE, 2'b10, n);
        repeat (5) cycle(1'b0, 2'b10, 1'b1, 1'b0);
        cycle(1'b0, 2'b10, 1'b1, 1'b1);
        chk("hm_score", int'(bus.score_bcd), 'h05);
        chk("hm_lives", int'(bus.lives), 2);
        chk("hm_state", int'(bus.state), M_SERVE);

        // reach 42 in play, then abort with reset
        hold_ticks(M_SERVE, 2'b10, n);
        repeat (37) cycle(1'b0, 2'b10, 1'b1, 1'b0);
        chk("score_42", int'(bus.score_bcd), 'h42);
        do_reset("arst_play");
        chk("arst_score", int'(bus.score_bcd), 'h00);
        chk("arst_lives", int'(bus.lives), 3);
        chk("arst_state", int'(bus.state), M_IDLE);
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        chk("idle_hit_score", int'(bus.score_bcd), 'h00);
        chk("idle_hit_state", int'(bus.state), M_IDLE);

        // random traffic against the model
        rb = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset("arst_rand");
            end else begin
                if ($urandom_range(0, 15) == 0) rb = 2'($urandom_range(0, 3));
                cycle(($urandom_range(0, 3) == 0), rb,
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // watchdog so the bench always ends
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
